// File: rtl/pc_select.sv
// ---------------------------------------------------------------------------
// pc_select -- fetch-address selection and next-pc prediction.
//
// Chooses the address presented to fetch (pc) from three sources: the
// corrected target of a mispredicted jump (m_valA), a return address from a
// ret in writeback (w_valM), or the registered prediction (pred_pc). It also
// tracks the processor status with a small FSM whose states are terminal once
// a halt, address error or illegal instruction is seen.
//
// Configuration macro:
//   PCSEL_JMP_TAKEN_EN  defined   -> jXX predicted taken (pred_pc <= f_valC)
//                       undefined -> jXX predicted not-taken (pred_pc <= f_valP)
//
// Parameters:
//   RESET_PC       pred_pc value loaded at reset
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   f_stall        fetch stall; holds pred_pc and state
//   f_icode        icode of the instruction at pc
//   f_valC         constant word of the instruction at pc
//   f_valP         fall-through address of the instruction at pc
//   f_halt         instruction at pc is halt
//   f_instr_valid  instruction at pc has a legal icode
//   f_imem_error   pc is outside instruction memory
//   m_mispredict   memory-stage jXX resolved against its prediction
//   m_valA         correct target for the mispredicted jXX
//   w_ret          ret in writeback
//   w_valM         return address for the ret in writeback
//   pc             address presented to fetch (combinational)
//   pred_pc        registered predicted next pc
//   stat           00 AOK, 01 HLT, 10 ADR, 11 INS (registered)
//   fetch_en       high only while running
// ---------------------------------------------------------------------------
module pc_select #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_stall,
    input  logic [3:0]  f_icode,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_halt,
    input  logic        f_instr_valid,
    input  logic        f_imem_error,
    input  logic        m_mispredict,
    input  logic [63:0] m_valA,
    input  logic        w_ret,
    input  logic [63:0] w_valM,
    output logic [63:0] pc,
    output logic [63:0] pred_pc,
    output logic [1:0]  stat,
    output logic        fetch_en
);

    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;

    // State encoding doubles as the stat code, so stat comes straight off
    // the state register.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HALT   = 2'b01,
        ADRERR = 2'b10,
        INSERR = 2'b11
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pred_pc_reg, pred_pc_next;
    logic [63:0] jxx_target;

    // Mispredict outranks ret: the mispredicted jump is older in the
    // pipeline than anything fetched after it, including a ret's target.
    always_comb begin
        if (m_mispredict) begin
            pc = m_valA;
        end else if (w_ret) begin
            pc = w_valM;
        end else begin
            pc = pred_pc_reg;
        end
    end

`ifdef PCSEL_JMP_TAKEN_EN
    assign jxx_target = f_valC;
`else
    assign jxx_target = f_valP;
`endif

    // Fetch outputs always describe the instruction at pc, so a redirect
    // coinciding with a fault simply reports the fault of the redirected
    // address; no separate handling is needed.
    always_comb begin
        state_next   = state_reg;
        pred_pc_next = pred_pc_reg;
        if (state_reg == RUN && !f_stall) begin
            if (f_imem_error) begin
                state_next = ADRERR;
            end else if (!f_instr_valid) begin
                state_next = INSERR;
            end else if (f_halt) begin
                state_next = HALT;
            end else begin
                state_next = RUN;
            end

            if (state_next == RUN) begin
                case (f_icode)
                    ICODE_CALL: pred_pc_next = f_valC;
                    ICODE_JXX:  pred_pc_next = jxx_target;
                    default:    pred_pc_next = f_valP;
                endcase
            end else begin
                // Leave pred_pc pointing at the offending instruction.
                pred_pc_next = pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            pred_pc_reg <= RESET_PC;
        end else begin
            state_reg   <= state_next;
            pred_pc_reg <= pred_pc_next;
        end
    end

    assign pred_pc  = pred_pc_reg;
    assign stat     = state_reg;
    assign fetch_en = (state_reg == RUN);

endmodule

// File: tb/tb_pc_select.sv
// ---------------------------------------------------------------------------
// tb_pc_select -- directed-vector bench for pc_select.
// Expected values are hand-computed constants; the jXX prediction constant
// follows PCSEL_JMP_TAKEN_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_pc_select;

    logic        clk;
    logic        rst_n;
    logic        f_stall;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_halt;
    logic        f_instr_valid;
    logic        f_imem_error;
    logic        m_mispredict;
    logic [63:0] m_valA;
    logic        w_ret;
    logic [63:0] w_valM;
    logic [63:0] pc;
    logic [63:0] pred_pc;
    logic [1:0]  stat;
    logic        fetch_en;

    int n_vec = 0;
    int n_err = 0;

`ifdef PCSEL_JMP_TAKEN_EN
    localparam logic [63:0] JXX_PRED = 64'd52;
`else
    localparam logic [63:0] JXX_PRED = 64'd50;
`endif

    pc_select #(.RESET_PC(64'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_stall       (f_stall),
        .f_icode       (f_icode),
        .f_valC        (f_valC),
        .f_valP        (f_valP),
        .f_halt        (f_halt),
        .f_instr_valid (f_instr_valid),
        .f_imem_error  (f_imem_error),
        .m_mispredict  (m_mispredict),
        .m_valA        (m_valA),
        .w_ret         (w_ret),
        .w_valM        (w_valM),
        .pc            (pc),
        .pred_pc       (pred_pc),
        .stat          (stat),
        .fetch_en      (fetch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a plain, legal, non-redirecting fetch word.
    task automatic fetch(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp);
        f_icode       = icode;
        f_valC        = valc;
        f_valP        = valp;
        f_halt        = (icode == 4'h0);
        f_instr_valid = 1'b1;
        f_imem_error  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; f_stall = 1'b0;
        m_mispredict = 1'b0; m_valA = '0; w_ret = 1'b0; w_valM = '0;
        fetch(4'h1, 64'd0, 64'd1);

        // Reset state
        step();
        check_vec("rst_pred_pc", pred_pc, 64'd0);
        check_vec("rst_stat", {62'd0, stat}, 64'd0);
        check_vec("rst_fetch_en", {63'd0, fetch_en}, 64'd1);
        check_vec("rst_pc", pc, 64'd0);
        rst_n = 1'b1;

        // nop at pc 0, valP = 1
        fetch(4'h1, 64'd0, 64'd1);
        step();
        check_vec("nop_pred_pc", pred_pc, 64'd1);
        check_vec("nop_stat", {62'd0, stat}, 64'd0);

        // Move to pc 3
        fetch(4'h1, 64'd0, 64'd3);
        step();
        check_vec("to3_pred_pc", pred_pc, 64'd3);

        // irmovq at pc 3 while stalled: holds
        f_stall = 1'b1;
        fetch(4'h3, 64'd99, 64'd13);
        step();
        check_vec("stall_pred_pc", pred_pc, 64'd3);
        // stall ignores fault inputs too
        f_imem_error = 1'b1;
        step();
        check_vec("stall_fault_stat", {62'd0, stat}, 64'd0);
        check_vec("stall_fault_pred", pred_pc, 64'd3);
        f_stall = 1'b0;
        fetch(4'h3, 64'd99, 64'd13);
        step();
        check_vec("irmov_pred_pc", pred_pc, 64'd13);

        // Move to pc 41, then jXX
        fetch(4'h1, 64'd0, 64'd41);
        step();
        check_vec("to41_pred_pc", pred_pc, 64'd41);
        fetch(4'h7, 64'd52, 64'd50);
        step();
        check_vec("jxx_pred_pc", pred_pc, JXX_PRED);

        // Mispredict redirect is combinational
        m_mispredict = 1'b1; m_valA = 64'd50;
        #1;
        check_vec("mispred_pc", pc, 64'd50);
        // w_ret alone, then both together
        m_mispredict = 1'b0; w_ret = 1'b1; w_valM = 64'h40;
        #1;
        check_vec("ret_pc", pc, 64'h40);
        m_mispredict = 1'b1; m_valA = 64'h30;
        #1;
        check_vec("ret_vs_mispred_pc", pc, 64'h30);

        // Redirected fetch of a call at 50: target 54
        w_ret = 1'b0; m_valA = 64'd50;
        fetch(4'h8, 64'd54, 64'd59);
        step();
        check_vec("call_pred_pc", pred_pc, 64'd54);
        m_mispredict = 1'b0;
        #1;
        check_vec("call_pc", pc, 64'd54);

        // halt at pc 54
        fetch(4'h0, 64'd0, 64'd55);
        step();
        check_vec("halt_stat", {62'd0, stat}, 64'd1);
        check_vec("halt_fetch_en", {63'd0, fetch_en}, 64'd0);
        check_vec("halt_pred_pc", pred_pc, 64'd54);

        // Terminal for 10 cycles despite redirects and new fetch words
        for (int i = 0; i < 10; i++) begin
            m_mispredict = i[0];
            m_valA       = 64'd200 + 64'(i);
            w_ret        = i[1];
            w_valM       = 64'd300;
            fetch(4'h1, 64'd0, 64'd400 + 64'(i));
            step();
            check_vec($sformatf("halt_hold%0d", i), {pred_pc[61:0], stat}, {62'd54, 2'b01});
        end
        m_mispredict = 1'b0; w_ret = 1'b0;

        do_reset();
        check_vec("rst2_pred_pc", pred_pc, 64'd0);
        check_vec("rst2_stat", {62'd0, stat}, 64'd0);
        check_vec("rst2_fetch_en", {63'd0, fetch_en}, 64'd1);

        // pc 120 with both memory error and illegal icode: ADR wins
        fetch(4'h1, 64'd0, 64'd120);
        step();
        check_vec("to120_pred_pc", pred_pc, 64'd120);
        f_imem_error = 1'b1; f_instr_valid = 1'b0;
        step();
        check_vec("adr_stat", {62'd0, stat}, 64'd2);
        check_vec("adr_pred_pc", pred_pc, 64'd120);

        // Reset overrides stall and the fault state
        f_stall = 1'b1;
        do_reset();
        check_vec("rst_over_stall_pred", pred_pc, 64'd0);
        check_vec("rst_over_stall_stat", {62'd0, stat}, 64'd0);
        f_stall = 1'b0;

        // Illegal instruction at pc 0
        fetch(4'hd, 64'd0, 64'd1);
        f_instr_valid = 1'b0;
        step();
        check_vec("ins_stat", {62'd0, stat}, 64'd3);
        check_vec("ins_pred_pc", pred_pc, 64'd0);

        // Redirect coincident with a memory error: pred_pc captures redirect
        do_reset();
        m_mispredict = 1'b1; m_valA = 64'd77;
        fetch(4'h1, 64'd0, 64'd78);
        f_imem_error = 1'b1;
        step();
        check_vec("redir_adr_stat", {62'd0, stat}, 64'd2);
        check_vec("redir_adr_pred", pred_pc, 64'd77);
        m_mispredict = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_select.md
PC_SELECT -- requirements
Module: pc_select

Interface
REQ-001 Parameter: RESET_PC, default 64'd0, pred_pc value loaded at reset.
REQ-002 Clocking: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-003 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 f_stall  input  1  hazard-unit stall of fetch; holds all state.
REQ-006 f_icode  input  4  icode of instruction at pc, from fetch.
REQ-007 f_valC  input  64  constant word from fetch.
REQ-008 f_valP  input  64  fall-through address from fetch.
REQ-009 f_halt  input  1  fetch decoded halt (icode 0).
REQ-010 f_instr_valid  input  1  fetch icode legal.
REQ-011 f_imem_error  input  1  fetch pc out of instruction memory (>119).
REQ-012 m_mispredict  input  1  memory-stage jXX resolved not-taken against prediction (or taken, per REQ-030).
REQ-013 m_valA  input  64  correct target for mispredicted jXX.
REQ-014 w_ret  input  1  ret in writeback; w_valM is return address.
REQ-015 w_valM  input  64  return address.
REQ-016 pc  output  64  address presented to fetch, combinational.
REQ-017 pred_pc  output  64  registered predicted next pc.
REQ-018 stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS; registered.
REQ-019 fetch_en  output  1  high only in state RUN.

Function
REQ-020 pc SHALL be m_valA if m_mispredict, else w_valM if w_ret, else pred_pc (mispredict highest priority).
REQ-021 States SHALL be RUN, HALT, ADRERR, INSERR; stat encodes AOK/HLT/ADR/INS respectively.
REQ-022 In RUN with f_stall=0, next state SHALL be ADRERR if f_imem_error, else INSERR if !f_instr_valid, else HALT if f_halt, else RUN.
REQ-023 In RUN with f_stall=0 and next state RUN, pred_pc SHALL load f_valC for f_icode 4'h8 (call), f_valC or f_valP for 4'h7 (jXX) per REQ-030, else f_valP.
REQ-024 On a RUN-to-non-RUN transition, pred_pc SHALL load pc (address of the faulting/halting instruction).
REQ-025 With f_stall=1, pred_pc and state SHALL hold; fetch status inputs ignored that cycle; pc still follows REQ-020.
REQ-026 Redirect (m_mispredict or w_ret) coincident with f_halt/f_imem_error SHALL apply REQ-022 to the redirected pc's fetch outputs, no special case.
REQ-027 HALT, ADRERR, INSERR SHALL be terminal until reset; pred_pc holds; redirect inputs only affect combinational pc.
REQ-028 Latency: one cycle from fetch outputs to pred_pc/stat update; pc zero-cycle.
REQ-029 All address arithmetic 64-bit unsigned; no addition inside block (valP supplied by fetch).

Reset
REQ-031 With rst_n=0 at posedge clk: pred_pc=RESET_PC, state RUN, stat=00, fetch_en=1; reset overrides f_stall and any in-progress fault.

Configuration
REQ-030 Macro PCSEL_JMP_TAKEN_EN: defined -> jXX predicted taken (pred_pc=f_valC), m_mispredict signals taken-wrong; undefined -> jXX predicted not-taken (pred_pc=f_valP), m_mispredict signals not-taken-wrong; call always f_valC.

Verification
REQ-032 Reset, then icode 1 at pc 0, valP=1 -> next cycle pred_pc=1, stat=00.
REQ-033 irmovq at pc 3, valP=13 -> pred_pc=13; f_stall=1 same setup -> pred_pc stays 3.
REQ-034 jXX at pc 41, valC=52, valP=50 -> pred_pc=52 with PCSEL_JMP_TAKEN_EN, 50 without; then m_mispredict=1, m_valA=50 -> pc=50 same cycle.
REQ-035 w_ret=1, w_valM=0x40 with m_mispredict=1, m_valA=0x30 -> pc=0x30.
REQ-036 halt at pc 54 -> stat=01, fetch_en=0, pred_pc=54 held for 10 cycles despite redirects; rst_n=0 -> pred_pc=0, stat=00.
REQ-037 pc=120 with f_imem_error=1 and f_instr_valid=0 -> stat=10 (ADR priority over INS).
